// File: rtl/uart_prog_loader.sv
// Serial program loader: parses 'L' (load) and 'G' (go) frames from the UART byte stream into the CPU program RAM.
// Optional inter-byte timeout is compiled in with `define LOADER_TIMEOUT_EN.
module uart_prog_loader #(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_rd,
    input  logic              tx_busy,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic [ADDR_W-1:0] start_addr
);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_TO   = 8'h54;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK,
        S_GADDR_HI, S_GADDR_LO, S_GO, S_REPLY_WAIT, S_REPLY_END
    } state_t;

    state_t            state_reg;
    logic [7:0]        hi_reg;
    logic [7:0]        sum_reg;
    logic [7:0]        cnt_reg;
    logic [ADDR_W-1:0] ptr_reg;

    logic              consuming;
    logic              accept;
    logic              timed_out;
    logic [15:0]       addr_full;
    logic [7:0]        sum_next;

    always_comb begin
        consuming = 1'b0;
        case (state_reg)
            S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK,
            S_GADDR_HI, S_GADDR_LO: consuming = 1'b1;
            default:                consuming = 1'b0;
        endcase
    end

    // rx_rd doubles as the "accepted last cycle" flag, spacing accepts two cycles apart
    assign accept    = rx_valid && consuming && !rx_rd;
    assign addr_full = {hi_reg, rx_data};
    assign sum_next  = sum_reg + rx_data;

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            counting;

    assign counting  = (state_reg != S_IDLE) && (state_reg != S_REPLY_WAIT) &&
                       (state_reg != S_REPLY_END);
    assign timed_out = counting && !accept && (to_cnt_reg >= TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            to_cnt_reg <= '0;
        end else if (accept || !counting || timed_out) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_reg  <= S_IDLE;
            hi_reg     <= '0;
            sum_reg    <= '0;
            cnt_reg    <= '0;
            ptr_reg    <= '0;
            rx_rd      <= 1'b0;
            tx_wr      <= 1'b0;
            tx_data    <= '0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            cpu_start  <= 1'b0;
            start_addr <= '0;
        end else begin
            rx_rd     <= accept;
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            tx_wr     <= 1'b0;
            if (timed_out) begin
                tx_data   <= RSP_TO;
                state_reg <= S_REPLY_WAIT;
            end else begin
                case (state_reg)
                    S_IDLE: if (accept) begin
                        if (rx_data == CMD_LOAD) begin
                            cpu_hold  <= 1'b1;
                            state_reg <= S_ADDR_HI;
                        end else if (rx_data == CMD_GO) begin
                            state_reg <= S_GADDR_HI;
                        end
                    end
                    S_ADDR_HI: if (accept) begin
                        hi_reg    <= rx_data;
                        sum_reg   <= rx_data;
                        state_reg <= S_ADDR_LO;
                    end
                    S_ADDR_LO: if (accept) begin
                        ptr_reg   <= addr_full[ADDR_W-1:0];
                        sum_reg   <= sum_next;
                        state_reg <= S_LEN;
                    end
                    S_LEN: if (accept) begin
                        sum_reg   <= sum_next;
                        cnt_reg   <= rx_data;
                        state_reg <= S_DATA;
                    end
                    // a count of 0 wraps to 255 on the first byte, giving 256 bytes in total
                    S_DATA: if (accept) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= ptr_reg;
                        mem_wdata <= rx_data;
                        ptr_reg   <= ptr_reg + ADDR_W'(1);
                        sum_reg   <= sum_next;
                        cnt_reg   <= cnt_reg - 8'd1;
                        if (cnt_reg == 8'd1) state_reg <= S_CHK;
                    end
                    S_CHK: if (accept) begin
                        sum_reg   <= sum_next;
                        tx_data   <= (sum_next == 8'h00) ? RSP_OK : RSP_ERR;
                        state_reg <= S_REPLY_WAIT;
                    end
                    S_GADDR_HI: if (accept) begin
                        hi_reg    <= rx_data;
                        state_reg <= S_GADDR_LO;
                    end
                    S_GADDR_LO: if (accept) begin
                        start_addr <= addr_full[ADDR_W-1:0];
                        state_reg  <= S_GO;
                    end
                    S_GO: begin
                        cpu_start <= 1'b1;
                        tx_data   <= RSP_OK;
                        state_reg <= S_REPLY_WAIT;
                    end
                    S_REPLY_WAIT: if (!tx_busy) begin
                        tx_wr     <= 1'b1;
                        state_reg <= S_REPLY_END;
                    end
                    S_REPLY_END: begin
                        cpu_hold  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule
